// File: rtl/dense_output_writer_if.sv
// ----------------------------------------------------------------------------
// dense_output_writer_if
// Groups the two streaming sides of the dense output writer:
//   - accumulator stream from the dense compute block
//       acc_valid (1), acc_data (signed 32), acc_addr (OUT_IDX_W)
//   - tensor RAM write port
//       tensor_ram_wready (1, from RAM), tensor_ram_we (1),
//       tensor_ram_waddr (ADDR_W), tensor_ram_din (8)
// Modports:
//   master : environment side (drives the accumulator stream and wready)
//   slave  : writer side (consumes accumulators, drives the RAM write port)
// ----------------------------------------------------------------------------
interface dense_output_writer_if #(
    parameter int ADDR_W    = 8,
    parameter int OUT_IDX_W = 6
);
    logic                    acc_valid;
    logic signed [31:0]      acc_data;
    logic [OUT_IDX_W-1:0]    acc_addr;
    logic                    tensor_ram_wready;
    logic                    tensor_ram_we;
    logic [ADDR_W-1:0]       tensor_ram_waddr;
    logic [7:0]              tensor_ram_din;

    modport master (
        output acc_valid, acc_data, acc_addr, tensor_ram_wready,
        input  tensor_ram_we, tensor_ram_waddr, tensor_ram_din
    );

    modport slave (
        input  acc_valid, acc_data, acc_addr, tensor_ram_wready,
        output tensor_ram_we, tensor_ram_waddr, tensor_ram_din
    );
endinterface

// File: rtl/dense_output_writer.sv
// ----------------------------------------------------------------------------
// dense_output_writer
// Sink for the dense layer's int32 accumulator stream. Accumulators are
// buffered in a small FIFO, requantized to int8 through a 3-stage pipe
// (Q31 multiply, rounding shift, saturate + zero point + clamp) and written
// to tensor RAM at base_addr + acc_addr (address wraps).
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 arm for a new layer; clears FIFO, pipe, counters
//   layer_complete        upstream has sent all outputs (level)
//   quant_mult            signed Q31 multiplier (>0)
//   quant_shift           extra right shift 0..31
//   out_zero_point        signed int8 output zero point
//   base_addr             tensor RAM base of the output vector
//   bus (slave)           accumulator stream in, tensor RAM write port out
//   write_count           writes completed this layer
//   busy                  ACTIVE or DRAIN
//   write_done            DONE
//   overflow_err          sticky: accumulator dropped on a full FIFO
//
// Build option:
//   DENSE_WR_RELU_EN  when defined, the lower output clamp is the zero point
//                     (fused ReLU); otherwise the lower clamp is -128.
// ----------------------------------------------------------------------------
module dense_output_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 8,
    parameter int OUT_IDX_W  = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     layer_complete,
    input  logic signed [31:0]       quant_mult,
    input  logic [4:0]               quant_shift,
    input  logic signed [7:0]        out_zero_point,
    input  logic [ADDR_W-1:0]        base_addr,
    dense_output_writer_if.slave     bus,
    output logic [OUT_IDX_W:0]       write_count,
    output logic                     busy,
    output logic                     write_done,
    output logic                     overflow_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;

    state_t state, state_next;

    // Round half toward +inf, then arithmetic shift by 31+sh.
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] p,
                                                       input logic [4:0] sh);
        logic [5:0]         s;
        logic signed [63:0] bias;
        s    = {1'b0, sh} + 6'd30;
        bias = 64'sd1 <<< s;
        return (p + bias) >>> (s + 6'd1);
    endfunction

    function automatic logic signed [31:0] sat32(input logic signed [63:0] r);
        if (r > 64'sd2147483647)
            return 32'sh7FFFFFFF;
        else if (r < -64'sd2147483648)
            return 32'sh80000000;
        else
            return r[31:0];
    endfunction

    function automatic logic [7:0] requant(input logic signed [63:0] r,
                                           input logic signed [7:0] zp);
        logic signed [32:0] v;
        logic signed [32:0] lo;
        v = 33'(sat32(r)) + 33'(zp);
`ifdef DENSE_WR_RELU_EN
        lo = 33'(zp);
`else
        lo = -33'sd128;
`endif
        if (v < lo)
            v = lo;
        else if (v > 33'sd127)
            v = 33'sd127;
        return v[7:0];
    endfunction

    // FIFO storage (data only, no reset) and control
    logic signed [31:0]   fifo_data [FIFO_DEPTH];
    logic [OUT_IDX_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [PTR_W:0]       fifo_count;
    logic                 fifo_full;

    // Pipe registers
    logic                 vld_p1, vld_p2, vld_p3;
    logic signed [63:0]   prod_p1;
    logic [4:0]           shift_p1;
    logic signed [7:0]    zp_p1, zp_p2;
    logic [ADDR_W-1:0]    waddr_p1, waddr_p2, waddr_p3;
    logic signed [63:0]   rnd_p2;
    logic [7:0]           q_p3;

    logic run, accept, advance, pop, push, drop, we, pipe_empty;

    assign run        = (state == ACTIVE) || (state == DRAIN);
    assign fifo_full  = (fifo_count == (PTR_W+1)'(FIFO_DEPTH));
    assign accept     = bus.acc_valid && run && !start;
    // The whole pipe freezes only when its last stage holds a result the RAM
    // cannot take; bubbles elsewhere do not cause a stall.
    assign advance    = !(vld_p3 && !bus.tensor_ram_wready);
    assign pop        = run && !start && (fifo_count != '0) && advance;
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign push       = accept && (!fifo_full || pop);
    assign drop       = accept && fifo_full && !pop;
    assign we         = vld_p3 && bus.tensor_ram_wready && !start && !reset;
    // An accumulator arriving this cycle keeps the writer out of DONE.
    assign pipe_empty = (fifo_count == '0) && !vld_p1 && !vld_p2 && !vld_p3 && !accept;

    assign bus.tensor_ram_we    = we;
    assign bus.tensor_ram_waddr = vld_p3 ? waddr_p3 : '0;
    assign bus.tensor_ram_din   = vld_p3 ? q_p3 : '0;

    assign busy       = run;
    assign write_done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = IDLE;
            ACTIVE:  if (layer_complete) state_next = DRAIN;
            DRAIN:   if (pipe_empty) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
        if (start)
            state_next = ACTIVE;
    end

    always_ff @(posedge clk) begin
        if (reset || start) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            vld_p1       <= 1'b0;
            vld_p2       <= 1'b0;
            vld_p3       <= 1'b0;
            write_count  <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            if (advance) begin
                vld_p1 <= pop;
                vld_p2 <= vld_p1;
                vld_p3 <= vld_p2;
            end
            if (we)
                write_count <= write_count + 1'b1;
            if (drop)
                overflow_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= bus.acc_data;
            fifo_addr[wr_ptr] <= bus.acc_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            // S1: Q31 multiply; per-entry config and address sampled here
            prod_p1  <= 64'(fifo_data[rd_ptr]) * 64'(quant_mult);
            shift_p1 <= quant_shift;
            zp_p1    <= out_zero_point;
            waddr_p1 <= base_addr + ADDR_W'(fifo_addr[rd_ptr]);
            // S2: rounding right shift
            rnd_p2   <= round_shift(prod_p1, shift_p1);
            zp_p2    <= zp_p1;
            waddr_p2 <= waddr_p1;
            // S3: saturate, add zero point, clamp to int8
            q_p3     <= requant(rnd_p2, zp_p2);
            waddr_p3 <= waddr_p2;
        end
    end

endmodule

// File: tb/tb_dense_output_writer.sv
module tb_dense_output_writer;
    localparam int ADDR_W    = 8;
    localparam int OUT_IDX_W = 6;
`ifdef DENSE_WR_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic                  layer_complete;
    logic signed [31:0]    quant_mult;
    logic [4:0]            quant_shift;
    logic signed [7:0]     out_zero_point;
    logic [ADDR_W-1:0]     base_addr;
    logic [OUT_IDX_W:0]    write_count;
    logic                  busy;
    logic                  write_done;
    logic                  overflow_err;

    dense_output_writer_if #(.ADDR_W(ADDR_W), .OUT_IDX_W(OUT_IDX_W)) bus_if ();

    dense_output_writer #(.FIFO_DEPTH(4), .ADDR_W(ADDR_W), .OUT_IDX_W(OUT_IDX_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .layer_complete (layer_complete),
        .quant_mult     (quant_mult),
        .quant_shift    (quant_shift),
        .out_zero_point (out_zero_point),
        .base_addr      (base_addr),
        .bus            (bus_if),
        .write_count    (write_count),
        .busy           (busy),
        .write_done     (write_done),
        .overflow_err   (overflow_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    typedef struct {
        int a;
        int d;
        int c;
    } wr_t;

    wr_t obs_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        wr_t w;
        if (bus_if.tensor_ram_we === 1'b1) begin
            w.a = int'(bus_if.tensor_ram_waddr);
            w.d = int'(bus_if.tensor_ram_din);
            w.c = cyc;
            obs_q.push_back(w);
        end
    end

    // Reference requantization: exact integer arithmetic with floor division.
    function automatic int ref_q(int acc, int mult, int sh, int zp);
        longint n, d, q, lo;
        n = longint'(acc) * longint'(mult) + (longint'(1) << (30 + sh));
        d = longint'(1) << (31 + sh);
        q = n / d;
        if ((n % d != 0) && (n < 0)) q = q - 1;
        if (q > 64'sd2147483647) q = 64'sd2147483647;
        if (q < -64'sd2147483648) q = -64'sd2147483648;
        q = q + zp;
        lo = RELU ? longint'(zp) : -128;
        if (q < lo) q = lo;
        if (q > 127) q = 127;
        return int'(q) & 255;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input int mult, input int sh, input int zp, input int base);
        quant_mult     = mult;
        quant_shift    = sh[4:0];
        out_zero_point = zp[7:0];
        base_addr      = base[ADDR_W-1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        obs_q.delete();
    endtask

    task automatic send(input int a, input int d, output int c);
        bus_if.acc_valid = 1'b1;
        bus_if.acc_addr  = a[OUT_IDX_W-1:0];
        bus_if.acc_data  = d;
        c = cyc;
        tick();
        bus_if.acc_valid = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int budget);
        int k = 0;
        while (obs_q.size() < n && k < budget) begin
            tick();
            k++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checks++; if (bus_if.tensor_ram_we !== 1'b0) $display("FAIL reset_we got %b want 0", bus_if.tensor_ram_we); else passed++;
        checks++; if (bus_if.tensor_ram_waddr !== 8'h00) $display("FAIL reset_waddr got %h want 00", bus_if.tensor_ram_waddr); else passed++;
        checks++; if (bus_if.tensor_ram_din !== 8'h00) $display("FAIL reset_din got %h want 00", bus_if.tensor_ram_din); else passed++;
        checks++; if (write_count !== 7'd0) $display("FAIL reset_count got %0d want 0", write_count); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        checks++; if (write_done !== 1'b0) $display("FAIL reset_done got %b want 0", write_done); else passed++;
        checks++; if (overflow_err !== 1'b0) $display("FAIL reset_ovf got %b want 0", overflow_err); else passed++;
    endtask

    task automatic test_basic();
        int c0;
        arm(32'h40000000, 0, 0, 8'h10);
        checks++; if (busy !== 1'b1) $display("FAIL basic_busy got %b want 1", busy); else passed++;
        send(3, 100, c0);
        wait_writes(1, 20);
        checks++; if (obs_q.size() != 1) $display("FAIL basic_nwr got %0d want 1", obs_q.size()); else passed++;
        if (obs_q.size() >= 1) begin
            checks++; if (obs_q[0].a != 8'h13) $display("FAIL basic_waddr got %0h want 13", obs_q[0].a); else passed++;
            checks++; if (obs_q[0].d != 50) $display("FAIL basic_din got %0d want 50", obs_q[0].d); else passed++;
            checks++; if (obs_q[0].c != c0 + 4) $display("FAIL basic_latency got %0d want %0d", obs_q[0].c - c0, 4); else passed++;
        end
        tick();
        checks++; if (write_count !== 7'd1) $display("FAIL basic_count got %0d want 1", write_count); else passed++;
    endtask

    task automatic test_rounding();
        int c;
        int accs[3] = '{3, -3, -4};
        int exps[3] = '{8'h02, 8'hFF, 8'hFE};
        arm(32'h40000000, 0, 0, 8'h10);
        for (int i = 0; i < 3; i++) send(i, accs[i], c);
        wait_writes(3, 20);
        checks++; if (obs_q.size() != 3) $display("FAIL round_nwr got %0d want 3", obs_q.size()); else passed++;
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i].d != exps[i]) $display("FAIL round_din%0d got %0h want %0h", i, obs_q[i].d, exps[i]); else passed++;
        end
    endtask

    task automatic test_saturation();
        int c;
        int exp_lo;
        arm(32'h40000000, 0, 10, 0);
        send(0, 1000, c);
        wait_writes(1, 20);
        checks++; if (obs_q.size() < 1 || obs_q[0].d != 127) $display("FAIL sat_hi got %0d want 127", obs_q.size() ? obs_q[0].d : -1); else passed++;
        arm(32'h40000000, 0, 0, 0);
        send(0, -1000, c);
        wait_writes(1, 20);
        exp_lo = RELU ? 8'h00 : 8'h80;
        checks++; if (obs_q.size() < 1 || obs_q[0].d != exp_lo) $display("FAIL sat_lo got %0h want %0h", obs_q.size() ? obs_q[0].d : -1, exp_lo); else passed++;
    endtask

    task automatic test_relu();
        int c;
        int expv;
        arm(32'h40000000, 0, -5, 0);
        send(1, -100, c);
        wait_writes(1, 20);
        expv = RELU ? 8'hFB : 8'hC9;
        checks++; if (obs_q.size() < 1 || obs_q[0].d != expv) $display("FAIL relu_din got %0h want %0h", obs_q.size() ? obs_q[0].d : -1, expv); else passed++;
    endtask

    task automatic test_stall();
        int c;
        arm(32'h40000000, 0, 0, 0);
        bus_if.tensor_ram_wready = 1'b0;
        for (int i = 0; i < 4; i++) send(i, 2 * (i + 1), c);
        repeat (4) tick();
        checks++; if (obs_q.size() != 0) $display("FAIL stall_held got %0d writes want 0", obs_q.size()); else passed++;
        checks++; if (overflow_err !== 1'b0) $display("FAIL stall_ovf0 got %b want 0", overflow_err); else passed++;
        bus_if.tensor_ram_wready = 1'b1;
        wait_writes(4, 20);
        checks++; if (obs_q.size() != 4) $display("FAIL stall_nwr got %0d want 4", obs_q.size()); else passed++;
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i].a != i || obs_q[i].d != i + 1) $display("FAIL stall_order%0d got %0h/%0d want %0h/%0d", i, obs_q[i].a, obs_q[i].d, i, i + 1); else passed++;
        end
        tick();
        checks++; if (write_count !== 7'd4) $display("FAIL stall_count got %0d want 4", write_count); else passed++;
        // Fill pipe (3) and FIFO (4), then one more pulse must be dropped.
        obs_q.delete();
        bus_if.tensor_ram_wready = 1'b0;
        for (int i = 0; i < 8; i++) send(10 + i, 2 * (10 + i), c);
        tick();
        checks++; if (overflow_err !== 1'b1) $display("FAIL full_ovf got %b want 1", overflow_err); else passed++;
        checks++; if (write_count !== 7'd4) $display("FAIL full_count got %0d want 4", write_count); else passed++;
        bus_if.tensor_ram_wready = 1'b1;
        wait_writes(7, 30);
        repeat (6) tick();
        checks++; if (obs_q.size() != 7) $display("FAIL full_nwr got %0d want 7", obs_q.size()); else passed++;
        for (int i = 0; i < 7 && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i].a != 10 + i || obs_q[i].d != 10 + i) $display("FAIL full_order%0d got %0h/%0d want %0h/%0d", i, obs_q[i].a, obs_q[i].d, 10 + i, 10 + i); else passed++;
        end
        checks++; if (write_count !== 7'd11) $display("FAIL full_count2 got %0d want 11", write_count); else passed++;
    endtask

    task automatic test_wrap_drain();
        int c;
        int k = 0;
        int done_cyc = -1;
        int exp_a[4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        arm(32'h40000000, 0, 0, 8'hFE);
        for (int i = 0; i < 4; i++) send(i, 2 * (i + 5), c);
        layer_complete = 1'b1;
        while (write_done !== 1'b1 && k < 30) begin
            tick();
            k++;
        end
        if (write_done === 1'b1) done_cyc = cyc;
        checks++; if (write_done !== 1'b1) $display("FAIL drain_done got %b want 1", write_done); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL drain_busy got %b want 0", busy); else passed++;
        checks++; if (obs_q.size() != 4) $display("FAIL wrap_nwr got %0d want 4", obs_q.size()); else passed++;
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i].a != exp_a[i] || obs_q[i].d != i + 5) $display("FAIL wrap%0d got %0h/%0d want %0h/%0d", i, obs_q[i].a, obs_q[i].d, exp_a[i], i + 5); else passed++;
        end
        if (obs_q.size() == 4) begin
            checks++; if (done_cyc <= obs_q[3].c) $display("FAIL drain_order got done %0d want after %0d", done_cyc, obs_q[3].c); else passed++;
        end
        layer_complete = 1'b0;
    endtask

    task automatic test_random();
        int c;
        int mult, sh, zp, base;
        int sent = 0;
        int a, d;
        wr_t e;
        wr_t exp_q[$];
        mult = int'($urandom_range(32'h7FFFFFFF, 1));
        sh   = int'($urandom_range(6, 0));
        zp   = int'($urandom_range(255, 0)) - 128;
        base = int'($urandom_range(255, 0));
        arm(mult, sh, zp, base);
        for (int i = 0; i < 80; i++) begin
            bus_if.tensor_ram_wready = ($urandom_range(3, 0) != 0);
            if ($urandom_range(1, 0) == 1 && (sent - obs_q.size()) < 4) begin
                a = int'($urandom_range(63, 0));
                d = int'($urandom);
                e.a = (base + a) % 256;
                e.d = ref_q(d, mult, sh, zp);
                e.c = 0;
                exp_q.push_back(e);
                sent++;
                send(a, d, c);
            end else begin
                tick();
            end
        end
        bus_if.tensor_ram_wready = 1'b1;
        wait_writes(sent, 60);
        checks++; if (obs_q.size() != sent) $display("FAIL rand_nwr got %0d want %0d", obs_q.size(), sent); else passed++;
        for (int i = 0; i < sent && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i].a != exp_q[i].a || obs_q[i].d != exp_q[i].d) $display("FAIL rand%0d got %0h/%0h want %0h/%0h", i, obs_q[i].a, obs_q[i].d, exp_q[i].a, exp_q[i].d); else passed++;
        end
        tick();
        checks++; if (int'(write_count) != sent) $display("FAIL rand_count got %0d want %0d", write_count, sent); else passed++;
        checks++; if (overflow_err !== 1'b0) $display("FAIL rand_ovf got %b want 0", overflow_err); else passed++;
    endtask

    task automatic test_reset_mid();
        int c;
        arm(32'h40000000, 0, 0, 8'h20);
        for (int i = 0; i < 3; i++) send(i, 40, c);
        reset = 1'b1;
        tick();
        checks++; if (bus_if.tensor_ram_we !== 1'b0) $display("FAIL midrst_we got %b want 0", bus_if.tensor_ram_we); else passed++;
        checks++; if (bus_if.tensor_ram_waddr !== 8'h00 || bus_if.tensor_ram_din !== 8'h00) $display("FAIL midrst_bus got %h/%h want 00/00", bus_if.tensor_ram_waddr, bus_if.tensor_ram_din); else passed++;
        checks++; if (busy !== 1'b0 || write_done !== 1'b0 || overflow_err !== 1'b0 || write_count !== 7'd0) $display("FAIL midrst_status got %b%b%b/%0d want 000/0", busy, write_done, overflow_err, write_count); else passed++;
        reset = 1'b0;
        repeat (8) tick();
        checks++; if (obs_q.size() != 0) $display("FAIL midrst_discard got %0d writes want 0", obs_q.size()); else passed++;
    endtask

    initial begin
        reset            = 1'b1;
        start            = 1'b0;
        layer_complete   = 1'b0;
        quant_mult       = 32'h40000000;
        quant_shift      = 5'd0;
        out_zero_point   = 8'sd0;
        base_addr        = '0;
        bus_if.acc_valid = 1'b0;
        bus_if.acc_data  = '0;
        bus_if.acc_addr  = '0;
        bus_if.tensor_ram_wready = 1'b1;
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_relu();
        test_stall();
        test_wrap_drain();
        test_random();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
